// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-cycle controller.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [5:0] CODE_BLANK = 6'd55;
  localparam logic [5:0] CODE_LAMP  = 6'd56;
  localparam logic [5:0] CODE_PAUSE = 6'd57;
  localparam logic [5:0] CODE_END   = 6'd58;

  localparam int unsigned DEF_WAT_MAX  = 8;
  localparam int unsigned DEF_WASH_SEC = 20;
  localparam int unsigned DEF_SPIN_SEC = 10;

  function automatic logic is_running(input state_t s);
    return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wash_stage_counter.sv
// 6-bit down-counter with synchronous load, tick enable and hold; flags count==1.
module wash_stage_counter #(
  parameter logic [5:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       tick,
  input  logic       hold,
  output logic [5:0] count,
  output logic       last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !hold && (count != '0)) begin
      count <= count - 6'd1;
    end
  end

  assign last = (count == 6'd1);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-cycle controller: FILL/WASH/DRAIN/SPIN on a 1 Hz tick, driving display values.
// Optional lamp test in IDLE is enabled by defining LAMP_TEST_EN.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned WAT_MAX  = DEF_WAT_MAX,
  parameter int unsigned WASH_SEC = DEF_WASH_SEC,
  parameter int unsigned SPIN_SEC = DEF_SPIN_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uTick,
  input  logic       uStart,
  input  logic       uPause,
  input  logic       uLamp,
  output logic [5:0] yTot,
  output logic [5:0] yCur,
  output logic [5:0] yWat,
  output logic [2:0] yStage,
  output logic       yDone
);

  localparam int unsigned TOTAL = 2 * WAT_MAX + WASH_SEC + SPIN_SEC;
  localparam logic [5:0] TOT6  = 6'(TOTAL);
  localparam logic [5:0] WAT6  = 6'(WAT_MAX);
  localparam logic [5:0] WASH6 = 6'(WASH_SEC);
  localparam logic [5:0] SPIN6 = 6'(SPIN_SEC);

  if ((TOTAL > 54) || (WAT_MAX < 1) || (WAT_MAX > 20) || (WASH_SEC < 1) || (SPIN_SEC < 1)) begin : g_param_check
    $error("wash_sequencer: duration parameters out of range");
  end

  state_t     state;
  state_t     saved_stage;
  logic [5:0] saved_cur;
  logic [5:0] wat;
  logic       done;

  logic [5:0] cur;
  logic [5:0] tot;
  logic       cur_last;
  logic       unused_tot_last;
  logic       running;
  logic       hold;

  logic       cur_load;
  logic [5:0] cur_val;
  logic       tot_load;
  logic [5:0] tot_val;

  assign running = is_running(state);
  // A pause pulse in a running stage swallows a coincident tick.
  assign hold    = !running || uPause;

`ifndef LAMP_TEST_EN
  logic unused_lamp;
  assign unused_lamp = uLamp;
`endif

  // The cur counter doubles as the yCur display register, so display codes are
  // loaded into it and the numeric value is parked in saved_cur during PAUSE.
  always_comb begin
    cur_load = 1'b0;
    cur_val  = cur;
    tot_load = 1'b0;
    tot_val  = tot;
    case (state)
      ST_IDLE: begin
        if (uStart) begin
          cur_load = 1'b1;
          cur_val  = WAT6;
          tot_load = 1'b1;
          tot_val  = TOT6;
        end
`ifdef LAMP_TEST_EN
        else begin
          cur_load = 1'b1;
          tot_load = 1'b1;
          cur_val  = uLamp ? CODE_LAMP : CODE_BLANK;
          tot_val  = uLamp ? CODE_LAMP : TOT6;
        end
`endif
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
        if (uPause) begin
          cur_load = 1'b1;
          cur_val  = CODE_PAUSE;
        end else if (uTick && cur_last) begin
          cur_load = 1'b1;
          case (state)
            ST_FILL:  cur_val = WASH6;
            ST_WASH:  cur_val = WAT6;
            ST_DRAIN: cur_val = SPIN6;
            default:  cur_val = CODE_END;
          endcase
        end
      end
      ST_PAUSE: begin
        if (uPause) begin
          cur_load = 1'b1;
          cur_val  = saved_cur;
        end
      end
      ST_DONE: begin
        if (uStart) begin
          cur_load = 1'b1;
          cur_val  = CODE_BLANK;
          tot_load = 1'b1;
          tot_val  = TOT6;
        end
      end
      default: ;
    endcase
  end

  wash_stage_counter #(.RST_VAL(CODE_BLANK)) u_cur (
    .clk      (clk),
    .rst      (rst),
    .load     (cur_load),
    .load_val (cur_val),
    .tick     (uTick),
    .hold     (hold),
    .count    (cur),
    .last     (cur_last)
  );

  wash_stage_counter #(.RST_VAL(TOT6)) u_tot (
    .clk      (clk),
    .rst      (rst),
    .load     (tot_load),
    .load_val (tot_val),
    .tick     (uTick),
    .hold     (hold),
    .count    (tot),
    .last     (unused_tot_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      saved_stage <= ST_FILL;
      saved_cur   <= '0;
      wat         <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (uStart) begin
            state <= ST_FILL;
            wat   <= '0;
          end
`ifdef LAMP_TEST_EN
          else begin
            wat <= uLamp ? CODE_LAMP : 6'd0;
          end
`endif
        end
        ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
          if (uPause) begin
            saved_stage <= state;
            saved_cur   <= cur;
            state       <= ST_PAUSE;
          end else if (uTick) begin
            case (state)
              ST_FILL:  wat <= wat + 6'd1;
              ST_WASH:  wat <= WAT6;
              ST_DRAIN: wat <= wat - 6'd1;
              default:  wat <= '0;
            endcase
            if (cur_last) begin
              case (state)
                ST_FILL:  state <= ST_WASH;
                ST_WASH:  state <= ST_DRAIN;
                ST_DRAIN: state <= ST_SPIN;
                default: begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              endcase
            end
          end
        end
        ST_PAUSE: begin
          if (uPause) begin
            state <= saved_stage;
          end
        end
        ST_DONE: begin
          if (uStart) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            wat   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign yTot   = tot;
  assign yCur   = cur;
  assign yWat   = wat;
  assign yStage = state;
  assign yDone  = done;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: directed vector table plus randomized run vs. a reference model.
module tb_wash_sequencer;

  localparam int W   = 8;
  localparam int WS  = 20;
  localparam int SS  = 10;
  localparam int TOT = 2 * W + WS + SS;

  logic       clk = 1'b0;
  logic       rst;
  logic       uTick, uStart, uPause, uLamp;
  logic [5:0] yTot, yCur, yWat;
  logic [2:0] yStage;
  logic       yDone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wash_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .uTick  (uTick),
    .uStart (uStart),
    .uPause (uPause),
    .uLamp  (uLamp),
    .yTot   (yTot),
    .yCur   (yCur),
    .yWat   (yWat),
    .yStage (yStage),
    .yDone  (yDone)
  );

  typedef struct {
    int         rep;
    logic       s, t, p;
    logic [5:0] et, ec, ew;
    logic [2:0] es;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int idx, input logic [5:0] et, ec, ew,
                       input logic [2:0] es, input logic ed);
    n_tests++;
    if ({yTot, yCur, yWat, yStage, yDone} !== {et, ec, ew, es, ed}) begin
      n_fail++;
      $display("FAIL %s[%0d]: got tot=%0d cur=%0d wat=%0d stage=%0d done=%0d, expected tot=%0d cur=%0d wat=%0d stage=%0d done=%0d",
               name, idx, yTot, yCur, yWat, yStage, yDone, et, ec, ew, es, ed);
    end
  endtask

  task automatic step(input logic s, input logic t, input logic p);
    uStart = s;
    uTick  = t;
    uPause = p;
    @(posedge clk);
    #1;
    uStart = 1'b0;
    uTick  = 1'b0;
    uPause = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  // Reference: a running cycle is fully described by elapsed ticks e since start.
  task automatic model_run(input int e, output logic [5:0] ec, output logic [5:0] ew,
                           output logic [2:0] es);
    int b1, b2, b3;
    b1 = W;
    b2 = W + WS;
    b3 = 2 * W + WS;
    if (e < b1) begin
      es = 3'd1; ec = 6'(b1 - e); ew = 6'(e);
    end else if (e < b2) begin
      es = 3'd2; ec = 6'(b2 - e); ew = 6'(W);
    end else if (e < b3) begin
      es = 3'd3; ec = 6'(b3 - e); ew = 6'(W - (e - b2));
    end else begin
      es = 3'd4; ec = 6'(TOT - e); ew = 6'd0;
    end
  endtask

  initial begin
    int mode, e;
    logic s, t, p;
    logic [5:0] ec, ew;
    logic [2:0] es;

    rst = 1'b1; uTick = 1'b0; uStart = 1'b0; uPause = 1'b0; uLamp = 1'b0;
    #12;
    check("reset", 0, 6'(TOT), 6'd55, 6'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    //            rep  s  t  p    tot  cur wat stg done
    tbl.push_back('{1,  0, 1, 1,   46, 55, 0,  0, 0});
    tbl.push_back('{1,  1, 0, 0,   46,  8, 0,  1, 0});
    tbl.push_back('{1,  0, 1, 0,   45,  7, 1,  1, 0});
    tbl.push_back('{7,  0, 1, 0,   38, 20, 8,  2, 0});
    tbl.push_back('{3,  0, 1, 0,   35, 17, 8,  2, 0});
    tbl.push_back('{1,  0, 0, 1,   35, 57, 8,  5, 0});
    tbl.push_back('{5,  0, 1, 0,   35, 57, 8,  5, 0});
    tbl.push_back('{1,  1, 0, 0,   35, 57, 8,  5, 0});
    tbl.push_back('{1,  0, 0, 1,   35, 17, 8,  2, 0});
    tbl.push_back('{1,  0, 1, 0,   34, 16, 8,  2, 0});
    tbl.push_back('{1,  1, 0, 0,   34, 16, 8,  2, 0});
    tbl.push_back('{15, 0, 1, 0,   19,  1, 8,  2, 0});
    tbl.push_back('{1,  0, 1, 0,   18,  8, 8,  3, 0});
    tbl.push_back('{1,  0, 1, 0,   17,  7, 7,  3, 0});
    tbl.push_back('{1,  0, 1, 1,   17, 57, 7,  5, 0});
    tbl.push_back('{1,  0, 0, 1,   17,  7, 7,  3, 0});
    tbl.push_back('{6,  0, 1, 0,   11,  1, 1,  3, 0});
    tbl.push_back('{1,  0, 1, 0,   10, 10, 0,  4, 0});
    tbl.push_back('{9,  0, 1, 0,    1,  1, 0,  4, 0});
    tbl.push_back('{1,  0, 1, 0,    0, 58, 0,  6, 1});
    tbl.push_back('{1,  0, 1, 1,    0, 58, 0,  6, 1});
    tbl.push_back('{1,  1, 0, 0,   46, 55, 0,  0, 0});

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) step(tbl[i].s, tbl[i].t, tbl[i].p);
      check("vec", i, tbl[i].et, tbl[i].ec, tbl[i].ew, tbl[i].es, tbl[i].ed);
    end

    // Asynchronous reset between edges, mid-WASH.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    check("pre_rst", 0, 6'd36, 6'd18, 6'd8, 3'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 6'(TOT), 6'd55, 6'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    check("restart", 0, 6'(TOT), 6'd8, 6'd0, 3'd1, 1'b0);

`ifdef LAMP_TEST_EN
    do_reset();
    uLamp = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("lamp_on", 0, 6'd56, 6'd56, 6'd56, 3'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("lamp_hold", 0, 6'd56, 6'd56, 6'd56, 3'd0, 1'b0);
    uLamp = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("lamp_off", 0, 6'(TOT), 6'd55, 6'd0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    uLamp = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("lamp_running", 0, 6'd45, 6'd7, 6'd1, 3'd1, 1'b0);
    uLamp = 1'b0;
`endif

    // Randomized run against the elapsed-tick reference model.
    do_reset();
    mode = 0;
    e    = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom % 24) == 0;
      t = $urandom % 2;
      p = ($urandom % 12) == 0;
      step(s, t, p);
      case (mode)
        0: if (s) begin mode = 1; e = 0; end
        1: if (p) mode = 2;
           else if (t) begin
             e++;
             if (e == TOT) mode = 3;
           end
        2: if (p) mode = 1;
        default: if (s) mode = 0;
      endcase
      case (mode)
        0: check("rand_idle", i, 6'(TOT), 6'd55, 6'd0, 3'd0, 1'b0);
        1: begin
          model_run(e, ec, ew, es);
          check("rand_run", i, 6'(TOT - e), ec, ew, es, 1'b0);
        end
        2: begin
          model_run(e, ec, ew, es);
          check("rand_pause", i, 6'(TOT - e), 6'd57, ew, 3'd5, 1'b0);
        end
        default: check("rand_done", i, 6'd0, 6'd58, 6'd0, 3'd6, 1'b1);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
